// File: rtl/cic_pkg.sv
// Shared constants and elaboration-time helpers for the CIC decimator.
package cic_pkg;

    localparam int unsigned DECIM_DEF = 25;
    localparam int unsigned ORDER_DEF = 3;
    localparam int unsigned OUT_W_DEF = 8;
    localparam int unsigned SHIFT_DEF = 7;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned    r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // 2 + ceil(order*log2(decim)), evaluated exactly as 2 + clog2(decim**order).
    function automatic int unsigned cic_reg_w(input int unsigned decim, input int unsigned order);
        longint unsigned gain;
        gain = 1;
        for (int unsigned i = 0; i < order; i++) begin
            gain = gain * longint'(decim);
        end
        return 2 + clog2(gain);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: dout = din - din(previous tick), delay updated on tick.
module cic_comb_stage #(
    parameter int unsigned REG_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic [REG_W-1:0] din,
    output logic [REG_W-1:0] dout
);

    logic [REG_W-1:0] dly;

    always_ff @(posedge clock) begin
        if (reset) begin
            dly <= '0;
        end else if (tick) begin
            dly <= din;
        end
    end

    // Modulo-2^REG_W difference; signedness is irrelevant for wrap-around arithmetic.
    assign dout = din - dly;

endmodule

// File: rtl/cic_decim.sv
// Sinc^ORDER decimator: 1-bit bitstream in, saturated OUT_W-bit PCM out every DECIM enabled clocks.
module cic_decim
    import cic_pkg::*;
#(
    parameter int unsigned DECIM = DECIM_DEF,
    parameter int unsigned ORDER = ORDER_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [OUT_W-1:0] pcm_o,
    output logic             pcm_valid,
    output logic             sat_o
);

    localparam int unsigned REG_W = cic_reg_w(DECIM, ORDER);
    localparam int unsigned CNT_W = clog2(longint'(DECIM));
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(DECIM - 1);
    localparam logic signed [REG_W-1:0] Y_MAX = REG_W'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [REG_W-1:0] Y_MIN = REG_W'(-(longint'(1) << (OUT_W - 1)));

    if (DECIM < 2 || ORDER < 1 || ORDER > 5 || REG_W > 32 || OUT_W > REG_W) begin : g_param_check
        $error("cic_decim: illegal parameter combination");
    end

    logic [REG_W-1:0] x_c;
    logic [REG_W-1:0] tap  [ORDER+1];
    logic [REG_W-1:0] comb [ORDER+1];
    logic [CNT_W-1:0] phase;
    logic             tick_c;
    logic signed [REG_W-1:0] y_c;

    // +1 for a one bit, -1 (all ones) for a zero bit.
    assign x_c    = bit_in ? REG_W'(1) : {REG_W{1'b1}};
    assign tap[0] = x_c;

    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        logic [REG_W-1:0] acc;

        always_ff @(posedge clock) begin
            if (reset) begin
                acc <= '0;
            end else if (bit_en) begin
                acc <= acc + tap[k];
            end
        end

        assign tap[k+1] = acc;
    end

    // Decimation phase; only enabled input cycles count toward a frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= '0;
        end else if (bit_en) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + CNT_W'(1);
        end
    end

    assign tick_c  = bit_en && (phase == PHASE_LAST);
    assign comb[0] = tap[ORDER];

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        cic_comb_stage #(
            .REG_W (REG_W)
        ) u_comb (
            .clock (clock),
            .reset (reset),
            .tick  (tick_c),
            .din   (comb[k]),
            .dout  (comb[k+1])
        );
    end

    assign y_c = $signed(comb[ORDER]) >>> SHIFT;

    // Scale and clip the comb result into the output register on the tick edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcm_o     <= '0;
            pcm_valid <= 1'b0;
            sat_o     <= 1'b0;
        end else begin
            pcm_valid <= tick_c;
            if (tick_c) begin
                if (y_c > Y_MAX) begin
                    pcm_o <= OUT_W'(Y_MAX);
                    sat_o <= 1'b1;
                end else if (y_c < Y_MIN) begin
                    pcm_o <= OUT_W'(Y_MIN);
                    sat_o <= 1'b1;
                end else begin
                    pcm_o <= y_c[OUT_W-1:0];
                    sat_o <= 1'b0;
                end
            end
        end
    end

endmodule
